imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writes a program image into instruction memory before the single-cycle CPU fetches it.
//  Input is a byte stream (valid/ready): a 16-bit big-endian word count N, then 4*N
//  big-endian instruction bytes. Output is the memory write port.
//  Holds the CPU (cpu_hold) while a load is in progress, then pulses done.
// PARAMETERS
//  ADDR_WIDTH  10             word-address width of instruction memory
//  MAX_WORDS   1<<ADDR_WIDTH  largest legal N
// PORTS
//  clk          in   1           single clock, all logic on posedge
//  reset        in   1           synchronous, active-high
//  load_start   in   1           1-cycle request to begin a load
//  in_data      in   8           stream byte
//  in_valid     in   1           in_data valid
//  in_ready     out  1           loader accepts in_data this cycle
//  mem_we       out  1           instruction memory write enable
//  mem_addr     out  ADDR_WIDTH  word address of write
//  mem_wdata    out  32          instruction word
//  cpu_hold     out  1           CPU must not fetch/execute while 1
//  done         out  1           1-cycle pulse: load completed
//  error        out  1           sticky: illegal N received
//  words_loaded out  16          words written in current/last load
// BEHAVIOUR
//  Reset: state=IDLE; every output is 0, including the mem_* outputs and words_loaded.
//  Reset mid-load aborts immediately: no further mem_we, partial word discarded.
//  Handshake: a byte is accepted on a cycle with in_valid&&in_ready.
//   in_ready is 1 only in LEN_HI, LEN_LO and DATA.
//   in_data is don't-care otherwise; in_valid may drop at any time (gaps allowed).
//  FSM:
//   IDLE  : load_start -> LEN_HI; clear error and words_loaded.
//   LEN_HI: accept byte -> N[15:8]; go to LEN_LO.
//   LEN_LO: accept byte -> N[7:0].
//           If N==0 or N>MAX_WORDS -> ERR, else -> DATA (byte_cnt=0, word_idx=0).
//   DATA  : accepted bytes shift in MSB-first (1st byte -> [31:24]); byte_cnt counts 0..3.
//           When byte 3 is accepted at cycle T: mem_we=1 at T+1, with mem_addr=word_idx
//             and mem_wdata=the assembled word; word_idx++ and words_loaded++ on that write.
//           The write cycle does not stall input: in_ready stays 1; bytes keep shifting.
//           When the final byte of word N-1 is accepted -> FLUSH.
//   FLUSH : carries the final mem_we; in_ready=0; -> DONE.
//   DONE  : done=1 for this cycle only; -> IDLE.
//   ERR   : error=1; no writes; cpu_hold stays 1; load_start -> LEN_HI.
//  mem_we is a 1-cycle pulse per word; exactly N pulses per legal load.
//   mem_addr is strictly ascending from 0 and never wraps (N<=MAX_WORDS).
//  mem_addr/mem_wdata hold their last values when mem_we=0.
//  cpu_hold=1 in LEN_HI, LEN_LO, DATA, FLUSH and ERR; 0 in IDLE and DONE.
//   It therefore falls in the same cycle done pulses.
//  load_start outside IDLE/ERR is ignored, including in its cycle of arrival.
//  error stays 1 until the next accepted load_start or reset.
//  words_loaded keeps its final value in IDLE until the next load_start.
// TESTING
//  1 assert reset 2 cycles -> all outputs 0, in_ready=0, no mem_we.
//  2 start; bytes 00 02 DE AD BE EF 01 23 45 67 back-to-back ->
//    writes [0]=DEADBEEF, [1]=01234567; done 1 cycle after final write; words_loaded=2.
//  3 same stream with in_valid low on alternate cycles ->
//    identical writes; in_ready high throughout DATA.
//  4 length 00 00, and separately N=MAX_WORDS+1 ->
//    error=1, zero mem_we pulses, cpu_hold=1; a legal load then clears error.
//  5 load_start pulsed during DATA -> ignored; reset after 6 data bytes ->
//    one write only ([0]), then IDLE with outputs 0.
//  6 N=MAX_WORDS with incrementing data ->
//    last write mem_addr=MAX_WORDS-1; exactly MAX_WORDS pulses; no wrap to 0.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: takes a length-prefixed big-endian byte stream
// and writes it as 32-bit words into instruction memory while the CPU is held.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    FLUSH,
    DONE,
    ERR
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [7:0]              len_hi;
  logic [15:0]             last_idx;
  logic [1:0]              byte_cnt;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [23:0]             shift;

  logic                    accept;
  logic [15:0]             len_full;
  logic                    len_bad;
  logic                    word_end;
  logic                    last_word;

  assign accept    = in_valid && in_ready;
  assign len_full  = {len_hi, in_data};
  assign len_bad   = (len_full == 16'd0) || (32'(len_full) > 32'(MAX_WORDS));
  assign word_end  = (byte_cnt == 2'd3);
  // last_idx is N-1, so the comparison is against the word being completed now
  assign last_word = (17'(word_idx) == {1'b0, last_idx});

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and state-decoded handshake/hold/done outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cpu_hold = 1'b0;
        if (load_start) state_next = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (accept) state_next = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (accept) state_next = len_bad ? ERR : DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        if (accept && word_end && last_word) state_next = FLUSH;
      end
      FLUSH: state_next = DONE;
      DONE: begin
        cpu_hold   = 1'b0;
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        if (load_start) state_next = LEN_HI;
      end
      default: begin
        cpu_hold   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: length capture, byte assembly, registered memory write and status
  always_ff @(posedge clk) begin
    if (reset) begin
      len_hi       <= '0;
      last_idx     <= '0;
      byte_cnt     <= '0;
      word_idx     <= '0;
      shift        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (load_start) begin
            error        <= 1'b0;
            words_loaded <= '0;
          end
        end
        LEN_HI: begin
          if (accept) len_hi <= in_data;
        end
        LEN_LO: begin
          if (accept) begin
            if (len_bad) begin
              error <= 1'b1;
            end else begin
              last_idx <= len_full - 16'd1;
              byte_cnt <= '0;
              word_idx <= '0;
              shift    <= '0;
            end
          end
        end
        DATA: begin
          if (accept) begin
            shift    <= {shift[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (word_end) begin
              mem_we       <= 1'b1;
              mem_addr     <= word_idx;
              mem_wdata    <= {shift, in_data};
              word_idx     <= word_idx + 1'b1;
              words_loaded <= words_loaded + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
